// File: rtl/seg_pkg.sv
// Shared types and constants for the binary-to-BCD display converter.
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    LOAD
  } state_t;

  localparam int ITER       = 32;         // shift iterations, equals input width
  localparam int BCD_DIGITS = 10;         // scratch digits, enough for 4294967295
  localparam int OUT_DIGITS = 8;          // digits presented to the scan driver
  localparam int OVF_LIMIT  = 100000000;  // first value that no longer fits in 8 digits

  typedef logic [3:0] bcd_digit_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more,
// so that the following left shift carries correctly into the next digit.
module bcd_digit_adj
  import seg_pkg::*;
(
  input  bcd_digit_t i_dig,
  output bcd_digit_t o_dig
);

  assign o_dig = (i_dig >= 4'd5) ? i_dig + 4'd3 : i_dig;

endmodule

// File: rtl/seg_bin2bcd.sv
// Sequential 32-bit binary to 8-digit packed BCD converter feeding the
// seven-segment scan driver. One shift-add-3 step per clock; the output
// register only updates at the end of a conversion.
// Optional: define SEG_HEX_BYPASS_EN to add a hex_mode input that shows the
// raw written value (one-cycle LOAD, no conversion).
module seg_bin2bcd
  import seg_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      LEDCtrl,
  input  logic [31:0]               write_data,
`ifdef SEG_HEX_BYPASS_EN
  input  logic                      hex_mode,
`endif
  output logic [OUT_DIGITS*4-1:0]   bcd_data,
  output logic                      busy,
  output logic                      done,
  output logic                      overflow
);

  localparam int CW = $clog2(ITER);

  state_t                     r_state;
  logic [31:0]                r_shf;
  bcd_digit_t [BCD_DIGITS-1:0] r_scr;
  logic [CW-1:0]              r_cnt;
  logic                       r_hex;
  logic                       r_pend;
  logic [31:0]                r_pend_val;
  logic                       r_pend_hex;
  logic [OUT_DIGITS*4-1:0]    r_bcd;
  logic                       r_busy;
  logic                       r_done;
  logic                       r_ovf;

  logic                       w_hex;
  bcd_digit_t [BCD_DIGITS-1:0] w_adj;
  logic [BCD_DIGITS*4-1:0]    w_scr_nxt;
  logic [31:0]                w_shf_nxt;
  logic [31:0]                w_next_val;
  logic                       w_next_hex;

`ifdef SEG_HEX_BYPASS_EN
  assign w_hex = hex_mode;
`else
  assign w_hex = 1'b0;
`endif

  // Per-digit add-3 correction ahead of each shift
  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .i_dig (r_scr[g]),
      .o_dig (w_adj[g])
    );
  end

  // {scratch, shift} moves left as one 72-bit register; the top bit of the
  // adjusted scratch falls off (it is always zero for 32-bit inputs)
  assign w_scr_nxt = (BCD_DIGITS*4)'({w_adj, r_shf[31]});
  assign w_shf_nxt = {r_shf[30:0], 1'b0};

  // At the LOAD edge a live strobe takes priority over the pending value
  assign w_next_val = LEDCtrl ? write_data : r_pend_val;
  assign w_next_hex = LEDCtrl ? w_hex      : r_pend_hex;

  // Control FSM, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_shf      <= '0;
      r_scr      <= '0;
      r_cnt      <= '0;
      r_hex      <= 1'b0;
      r_pend     <= 1'b0;
      r_pend_val <= '0;
      r_pend_hex <= 1'b0;
      r_bcd      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (LEDCtrl) begin
            r_shf   <= write_data;
            r_scr   <= '0;
            r_cnt   <= '0;
            r_hex   <= w_hex;
            r_busy  <= 1'b1;
            r_state <= w_hex ? LOAD : CONV;
          end
        end
        CONV: begin
          r_scr <= w_scr_nxt;
          r_shf <= w_shf_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(ITER - 1)) r_state <= LOAD;
          // Writes during a conversion are parked; the newest one wins
          if (LEDCtrl) begin
            r_pend     <= 1'b1;
            r_pend_val <= write_data;
            r_pend_hex <= w_hex;
          end
        end
        LOAD: begin
          if (r_hex) begin
            r_bcd <= r_shf;
            r_ovf <= 1'b0;
          end else begin
            r_bcd <= r_scr[OUT_DIGITS-1:0];
            r_ovf <= |r_scr[BCD_DIGITS-1:OUT_DIGITS];
          end
          r_done <= 1'b1;
          if (LEDCtrl || r_pend) begin
            r_shf   <= w_next_val;
            r_scr   <= '0;
            r_cnt   <= '0;
            r_hex   <= w_next_hex;
            r_pend  <= 1'b0;
            r_state <= w_next_hex ? LOAD : CONV;
          end else begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bcd_data = r_bcd;
  assign busy     = r_busy;
  assign done     = r_done;
  assign overflow = r_ovf;

endmodule
